// File: rtl/write_ddr_control_pkg.sv
// Shared types and constants for the DDR write controller (64-beat INCR bursts on AXI4).
// Also supplies default widths when the MEM_ADDR_WIDTH / MEM_DATA_WIDTH macros are not set.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif

package write_ddr_control_pkg;

  typedef enum logic [1:0] {
    WRITE_IDLE = 2'd0,
    WRITE_REQ  = 2'd1,
    WRITE_DATA = 2'd2,
    WRITE_RESP = 2'd3
  } write_state_e;

  // Each burst covers 64 beats x 64 bytes = one 4 KiB page.
  localparam logic [31:0] BURST_STRIDE    = 32'h1000;
  localparam int          BEATS_PER_BURST = 64;

  localparam logic [7:0] AXI_AWLEN   = 8'(BEATS_PER_BURST - 1);
  localparam logic [2:0] AXI_AWSIZE  = 3'b110;
  localparam logic [1:0] AXI_AWBURST = 2'b01;
  localparam logic [3:0] AXI_AWCACHE = 4'b0011;
  localparam logic [1:0] BRESP_OKAY  = 2'b00;
  localparam logic [5:0] LAST_BEAT   = 6'(BEATS_PER_BURST - 1);

endpackage

// File: rtl/write_ddr_control.sv
// Streams an output feature map to DDR as a series of 64-beat AXI4 write bursts, one outstanding.
// Optional feature: define WRITE_RESP_CHECK_EN to latch a sticky write_error on any non-OKAY BRESP.
//
// Handshakes: a transfer happens on a channel in exactly the cycle where its valid and ready are
// both high; valid never depends on ready. Upstream beats pass straight through in WRITE_DATA, so
// write_data_valid/write_data_ready behave as the W channel's wvalid/wready.
module write_ddr_control
  import write_ddr_control_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH
) (
  input  logic                        system_clk,
  input  logic                        rst_n,
  input  logic                        task_start,
  input  logic [MEM_ADDR_WIDTH-1:0]   write_base_addr,
  input  logic [15:0]                 write_burst_num,
  input  logic                        write_burst_avail,
  input  logic [MEM_DATA_WIDTH-1:0]   write_data,
  input  logic                        write_data_valid,
  output logic                        write_data_ready,
  output logic                        write_done,
  output logic                        write_error,
  output logic [MEM_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [7:0]                  m00_axi_awlen,
  output logic [2:0]                  m00_axi_awsize,
  output logic [1:0]                  m00_axi_awburst,
  output logic                        m00_axi_awlock,
  output logic [3:0]                  m00_axi_awcache,
  output logic [2:0]                  m00_axi_awprot,
  output logic [3:0]                  m00_axi_awqos,
  output logic                        m00_axi_awvalid,
  input  logic                        m00_axi_awready,
  output logic [MEM_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [MEM_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                        m00_axi_wlast,
  output logic                        m00_axi_wvalid,
  input  logic                        m00_axi_wready,
  input  logic [1:0]                  m00_axi_bresp,
  input  logic                        m00_axi_bvalid,
  output logic                        m00_axi_bready,
  output logic [1:0]                  dbg_state
);

  write_state_e              state_q, state_d;
  logic [15:0]               burst_cnt_q, burst_cnt_d;
  logic [5:0]                beat_cnt_q, beat_cnt_d;
  logic                      write_req_q, write_req_d;
  logic [MEM_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]               num_q, num_d;
  logic                      abandon_q, abandon_d;
  logic                      zero_done_q, zero_done_d;

  logic w_fire;
  logic b_fire;
  logic last_burst;
  logic task_done;
  logic beat_last;

  assign beat_last  = (beat_cnt_q == LAST_BEAT);
  assign w_fire     = (state_q == WRITE_DATA) && write_data_valid && m00_axi_wready;
  assign b_fire     = (state_q == WRITE_RESP) && m00_axi_bvalid;
  assign last_burst = (burst_cnt_q == (num_q - 16'd1));
  // A burst finishing after a mid-flight task_start belongs to the old task: no count, no done.
  assign task_done  = b_fire && !abandon_q && write_req_q && last_burst;

  // State register
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WRITE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WRITE_IDLE: if (write_req_q && write_burst_avail && !task_start) state_d = WRITE_REQ;
      WRITE_REQ:  if (m00_axi_awready) state_d = WRITE_DATA;
      WRITE_DATA: if (w_fire && beat_last) state_d = WRITE_RESP;
      WRITE_RESP: if (m00_axi_bvalid) state_d = WRITE_IDLE;
      default:    state_d = WRITE_IDLE;
    endcase
  end

  // Task bookkeeping and burst address generation
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    write_req_d = write_req_q;
    awaddr_d    = awaddr_q;
    base_d      = base_q;
    num_d       = num_q;
    abandon_d   = abandon_q;
    zero_done_d = 1'b0;

    if ((state_q == WRITE_IDLE) && (state_d == WRITE_REQ)) begin
      awaddr_d = base_q + MEM_ADDR_WIDTH'(burst_cnt_q) * MEM_ADDR_WIDTH'(BURST_STRIDE);
    end

    if (w_fire) begin
      beat_cnt_d = beat_last ? 6'd0 : beat_cnt_q + 6'd1;
    end

    if (b_fire) begin
      abandon_d = 1'b0;
      if (!abandon_q) begin
        burst_cnt_d = burst_cnt_q + 16'd1;
        if (last_burst) write_req_d = 1'b0;
      end
    end

    // A new task never cuts the AXI burst short; the in-flight burst is marked as abandoned.
    if (task_start) begin
      base_d      = write_base_addr;
      num_d       = write_burst_num;
      burst_cnt_d = 16'd0;
      write_req_d = (write_burst_num != 16'd0);
      zero_done_d = (write_burst_num == 16'd0);
      abandon_d   = (state_q != WRITE_IDLE) && !b_fire;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
      write_req_q <= 1'b0;
      awaddr_q    <= '0;
      base_q      <= '0;
      num_q       <= '0;
      abandon_q   <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      write_req_q <= write_req_d;
      awaddr_q    <= awaddr_d;
      base_q      <= base_d;
      num_q       <= num_d;
      abandon_q   <= abandon_d;
      zero_done_q <= zero_done_d;
    end
  end

  // Output logic
  always_comb begin
    m00_axi_awvalid  = (state_q == WRITE_REQ);
    m00_axi_awaddr   = awaddr_q;
    m00_axi_wvalid   = (state_q == WRITE_DATA) && write_data_valid;
    write_data_ready = (state_q == WRITE_DATA) && m00_axi_wready;
    m00_axi_wlast    = (state_q == WRITE_DATA) && beat_last;
    m00_axi_wdata    = write_data;
    m00_axi_wstrb    = '1;
    m00_axi_bready   = (state_q == WRITE_RESP);
    write_done       = zero_done_q || task_done;
    dbg_state        = state_q;
  end

  assign m00_axi_awlen   = AXI_AWLEN;
  assign m00_axi_awsize  = AXI_AWSIZE;
  assign m00_axi_awburst = AXI_AWBURST;
  assign m00_axi_awlock  = 1'b0;
  assign m00_axi_awcache = AXI_AWCACHE;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awqos   = 4'b0000;

`ifdef WRITE_RESP_CHECK_EN
  logic error_q, error_d;

  always_comb begin
    error_d = error_q;
    if (b_fire && (m00_axi_bresp != BRESP_OKAY)) error_d = 1'b1;
    if (task_start) error_d = 1'b0;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign write_error = error_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^m00_axi_bresp;
  assign write_error  = 1'b0;
`endif

endmodule

// File: tb/tb_write_ddr_control.sv
// Directed bench for write_ddr_control: a table of write tasks run against a simple AXI slave
// model, plus hand-written sequences for reset mid-burst and task_start mid-burst.
module tb_write_ddr_control;

  localparam int AW = 32;
  localparam int DW = 512;

  logic           system_clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           task_start = 1'b0;
  logic [AW-1:0]  write_base_addr = '0;
  logic [15:0]    write_burst_num = '0;
  logic           write_burst_avail = 1'b0;
  logic [DW-1:0]  write_data = '0;
  logic           write_data_valid = 1'b0;
  logic           write_data_ready;
  logic           write_done;
  logic           write_error;
  logic [AW-1:0]  awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awlock;
  logic [3:0]     awcache;
  logic [2:0]     awprot;
  logic [3:0]     awqos;
  logic           awvalid;
  logic           awready = 1'b0;
  logic [DW-1:0]  wdata;
  logic [DW/8-1:0] wstrb;
  logic           wlast;
  logic           wvalid;
  logic           wready = 1'b0;
  logic [1:0]     bresp = 2'b00;
  logic           bvalid = 1'b0;
  logic           bready;
  logic [1:0]     dbg_state;

  always #5 system_clk = ~system_clk;

  write_ddr_control #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
    .system_clk(system_clk), .rst_n(rst_n), .task_start(task_start),
    .write_base_addr(write_base_addr), .write_burst_num(write_burst_num),
    .write_burst_avail(write_burst_avail), .write_data(write_data),
    .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
    .write_done(write_done), .write_error(write_error),
    .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
    .m00_axi_awburst(awburst), .m00_axi_awlock(awlock), .m00_axi_awcache(awcache),
    .m00_axi_awprot(awprot), .m00_axi_awqos(awqos), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wlast(wlast), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [31:0] base;
    logic [15:0] num;
    int          wr_mode;
    int          aw_mode;
    int          avail_delay;
    int          bad_burst;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  int src_cnt = 0;
  int sb_cnt = 0;
  int beat_in_burst = 0;
  bit b_pending = 1'b0;

  function automatic logic [DW-1:0] pattern(input int n);
    logic [DW-1:0] p;
    for (int k = 0; k < DW / 32; k++) p[k*32 +: 32] = 32'(n) + (32'(k) << 24);
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vector(input logic [31:0] base, input logic [15:0] num, input int wr_mode,
                            input int aw_mode, input int avail_delay, input int bad_burst,
                            input int stop_beats);
    int aw_cnt = 0;
    int b_cnt = 0;
    int done_cnt = 0;
    int done_i = -100;
    int beats = 0;
    bit finished = 1'b0;
    bit stopped = 1'b0;
    bit exp_done;
    logic exp_err = 1'b0;
    int i;
    for (int k = 0; k < int'(num); k++) exp_q.push_back(base + 32'(k) * 32'h1000);
    for (i = -1; i < 4000 && !finished && !stopped; i++) begin
      @(negedge system_clk);
      task_start        = (i == -1);
      write_base_addr   = base;
      write_burst_num   = num;
      write_burst_avail = (i >= avail_delay);
      awready           = (aw_mode == 0) ? 1'b1 : ((i % 3) == 2);
      wready            = (wr_mode == 0) ? 1'b1 : ((i % 2) == 1);
      write_data_valid  = 1'b1;
      write_data        = pattern(src_cnt);
      bvalid            = b_pending;
      bresp             = (b_cnt < aw_cnt && b_cnt == bad_burst) ? 2'b10 : 2'b00;
      #1;
      if (i == 0) check("error_clear_on_start", 64'(write_error), 64'd0);
      if (i <= avail_delay) check("aw_held_until_avail", 64'(awvalid), 64'd0);
      check("aw_w_not_together", 64'(awvalid && wvalid), 64'd0);
      if (write_data_valid && write_data_ready) src_cnt++;
      exp_done = (num == 16'd0 && i == 0);
      if (awvalid && awready) begin
        check("awlen", 64'(awlen), 64'd63);
        check("aw_consts", {awsize, awburst, awlock, awcache, awprot, awqos},
              {3'b110, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_aw actual=%0h required=none", awaddr);
        end else begin
          check("awaddr", 64'(awaddr), 64'(exp_q.pop_front()));
        end
        aw_cnt++;
      end
      if (wvalid && wready) begin
        checks++;
        if (wdata !== pattern(sb_cnt)) begin
          errors++;
          $display("FAIL wdata beat %0d actual=%0h required=%0h", sb_cnt, wdata[63:0], pattern(sb_cnt) >> 0 & 64'hFFFF_FFFF_FFFF_FFFF);
        end
        check("wlast", 64'(wlast), 64'(beat_in_burst == 63));
        check("wstrb", 64'(wstrb), {64{1'b1}});
        sb_cnt++;
        beats++;
        if (beat_in_burst == 63) begin
          beat_in_burst = 0;
          b_pending = 1'b1;
        end else begin
          beat_in_burst++;
        end
        if (stop_beats != 0 && beats == stop_beats) stopped = 1'b1;
      end
      if (bvalid && bready) begin
        b_pending = 1'b0;
        if (b_cnt < aw_cnt) begin
          exp_done = (b_cnt == int'(num) - 1);
          if (bresp != 2'b00) exp_err = 1'b1;
          b_cnt++;
        end
      end
      check("write_done", 64'(write_done), 64'(exp_done));
      if (write_done) begin
        done_cnt++;
        done_i = i;
      end
      if (done_cnt > 0 && i >= done_i + ((num == 16'd0) ? 10 : 2)) finished = 1'b1;
    end
    if (!stopped) begin
      if (!finished) begin
        checks++; errors++;
        $display("FAIL task_timeout actual=no_done required=done base=%0h", base);
      end
      check("aw_all_issued", 64'(exp_q.size()), 64'd0);
      check("done_count", 64'(done_cnt), 64'd1);
`ifdef WRITE_RESP_CHECK_EN
      check("write_error", 64'(write_error), 64'(exp_err));
`else
      check("write_error", 64'(write_error), 64'd0);
`endif
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_awvalid"}, 64'(awvalid), 64'd0);
    check({tag, "_wvalid"}, 64'(wvalid), 64'd0);
    check({tag, "_wlast"}, 64'(wlast), 64'd0);
    check({tag, "_bready"}, 64'(bready), 64'd0);
    check({tag, "_data_ready"}, 64'(write_data_ready), 64'd0);
    check({tag, "_done"}, 64'(write_done), 64'd0);
    check({tag, "_error"}, 64'(write_error), 64'd0);
    check({tag, "_awaddr"}, 64'(awaddr), 64'd0);
  endtask

  initial begin
    vecs[0] = '{32'h1000_0000, 16'd2, 0, 0, 0, -1};
    vecs[1] = '{32'h2000_0000, 16'd3, 1, 1, 0, -1};
    vecs[2] = '{32'h2400_0000, 16'd1, 0, 0, 20, -1};
    vecs[3] = '{32'h3000_0000, 16'd2, 0, 0, 0, 1};
    vecs[4] = '{32'h4000_0000, 16'd0, 0, 0, 0, -1};
    vecs[5] = '{32'h0FFF_F000, 16'd2, 1, 0, 3, -1};

    rst_n = 1'b0;
    repeat (3) @(negedge system_clk);
    #1;
    check_all_quiet("reset");
    @(negedge system_clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_vector(vecs[v].base, vecs[v].num, vecs[v].wr_mode, vecs[v].aw_mode,
                 vecs[v].avail_delay, vecs[v].bad_burst, 0);
    end

    // Reset at beat 30 of the first burst, then a fresh task from its own base.
    run_vector(32'h5000_0000, 16'd2, 0, 0, 0, -1, 30);
    @(negedge system_clk);
    rst_n = 1'b0;
    #1;
    check_all_quiet("mid_reset");
    exp_q.delete();
    beat_in_burst = 0;
    b_pending = 1'b0;
    bvalid = 1'b0;
    repeat (2) @(negedge system_clk);
    rst_n = 1'b1;
    run_vector(32'h6000_0000, 16'd1, 0, 0, 0, -1, 0);

    // New task_start while a burst is in flight: the burst completes, then the new task runs.
    run_vector(32'h7000_0000, 16'd3, 0, 0, 0, -1, 10);
    exp_q.delete();
    run_vector(32'h8000_0000, 16'd2, 1, 0, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
